ad1868_deserializer: RTL and testbench

Single-clock front end that recovers AD1868-format serial audio (bit clock, per-channel data, latch) into parallel left/right sample words in the I2S master-clock domain. Sits directly upstream of the I2S encoder. It replaces the ad-clock-domain holding stage: all AD1868 inputs are oversampled on the master clock, so every downstream consumer sees one clock and a qualified sample-valid strobe.

---
 rtl/ad1868_pkg.sv | 21 ++
 rtl/ad1868_deserializer_if.sv | 28 ++
 rtl/ad1868_deserializer_ad_input_sync.sv | 38 +++
 rtl/ad1868_deserializer.sv | 142 ++++++++++++++
 tb/tb_ad1868_deserializer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad1868_pkg.sv
// Shared types and constants for the AD1868 serial-audio deserializer.
package ad1868_pkg;

   localparam int unsigned AD1868_WIDTH_DEFAULT = 16;
   localparam int unsigned ERR_CNT_W            = 8;
   localparam int unsigned BIT_CNT_W            = 5;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } des_state_t;

   // The four AD1868 pins, synchronized and edge-detected as one bundle.
   typedef struct packed {
      logic latch;
      logic data_r;
      logic data_l;
      logic clk;
   } ad_bits_t;

endpackage

// File: rtl/ad1868_deserializer_if.sv
// AD1868 serial inputs and recovered parallel sample outputs of the deserializer.
interface ad1868_deserializer_if
   import ad1868_pkg::*;
#(
   parameter int unsigned WIDTH = AD1868_WIDTH_DEFAULT
);

   logic                 i_ad_clk;
   logic                 i_ad_data_l;
   logic                 i_ad_data_r;
   logic                 i_ad_latch;
   logic [WIDTH-1:0]     o_data_l;
   logic [WIDTH-1:0]     o_data_r;
   logic                 o_valid;
   logic                 o_locked;
   logic [ERR_CNT_W-1:0] o_err_cnt;

   modport slave (
      input  i_ad_clk, i_ad_data_l, i_ad_data_r, i_ad_latch,
      output o_data_l, o_data_r, o_valid, o_locked, o_err_cnt
   );

   modport master (
      output i_ad_clk, i_ad_data_l, i_ad_data_r, i_ad_latch,
      input  o_data_l, o_data_r, o_valid, o_locked, o_err_cnt
   );

endinterface

// File: rtl/ad1868_deserializer_ad_input_sync.sv
// N-bit multi-stage synchronizer with history register and registered rise/fall strobes.
module ad_input_sync #(
   parameter int unsigned N      = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic         i_mclk,
   input  logic         i_rst,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_level,
   output logic [N-1:0] o_rise,
   output logic [N-1:0] o_fall
);

   logic [STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0]             hist_q;
   logic [N-1:0]             rise_q;
   logic [N-1:0]             fall_q;

   // hist_q is the synchronized level aligned with the registered strobes
   always_ff @(posedge i_mclk) begin
      if (i_rst) begin
         sync_q <= '0;
         hist_q <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
         hist_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~hist_q;
         fall_q <= ~sync_q[STAGES-1] & hist_q;
      end
   end

   assign o_level = hist_q;
   assign o_rise  = rise_q;
   assign o_fall  = fall_q;

endmodule

// File: rtl/ad1868_deserializer.sv
// Recovers AD1868 serial audio into parallel L/R words in the master-clock domain.
// Optional short-word statistics: define AD1868_DESER_STATS_EN.
module ad1868_deserializer
   import ad1868_pkg::*;
#(
   parameter int unsigned WIDTH       = AD1868_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  i_mclk,
   input  logic                  i_rst,
   ad1868_deserializer_if.slave  bus
);

   localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;
   localparam logic [BIT_CNT_W-1:0] WORD_BITS   = BIT_CNT_W'(WIDTH);

   ad_bits_t pin;
   ad_bits_t lvl;
   ad_bits_t rise;
   ad_bits_t fall;
   logic     unused_edges;

   assign pin.clk    = bus.i_ad_clk;
   assign pin.data_l = bus.i_ad_data_l;
   assign pin.data_r = bus.i_ad_data_r;
   assign pin.latch  = bus.i_ad_latch;

   ad_input_sync #(
      .N      ($bits(ad_bits_t)),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_mclk  (i_mclk),
      .i_rst   (i_rst),
      .i_d     (pin),
      .o_level (lvl),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   assign unused_edges = ^{lvl.clk, lvl.latch, rise.data_l, rise.data_r, rise.latch,
                           fall.clk, fall.data_l, fall.data_r};

   des_state_t           state_q, state_d;
   logic [WIDTH-1:0]     sh_l_q, sh_l_d;
   logic [WIDTH-1:0]     sh_r_q, sh_r_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     data_l_q, data_l_d;
   logic [WIDTH-1:0]     data_r_q, data_r_d;
   logic                 valid_q, valid_d;
   logic                 locked_q, locked_d;
`ifdef AD1868_DESER_STATS_EN
   logic [ERR_CNT_W-1:0] err_q, err_d;
`endif

   always_ff @(posedge i_mclk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         sh_l_q   <= '0;
         sh_r_q   <= '0;
         cnt_q    <= '0;
         data_l_q <= '0;
         data_r_q <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
`ifdef AD1868_DESER_STATS_EN
         err_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sh_l_q   <= sh_l_d;
         sh_r_q   <= sh_r_d;
         cnt_q    <= cnt_d;
         data_l_q <= data_l_d;
         data_r_q <= data_r_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
`ifdef AD1868_DESER_STATS_EN
         err_q    <= err_d;
`endif
      end
   end

   // A coincident bit edge is shifted before the latch decision sees the word
   always_comb begin
      state_d  = state_q;
      sh_l_d   = sh_l_q;
      sh_r_d   = sh_r_q;
      cnt_d    = cnt_q;
      data_l_d = data_l_q;
      data_r_d = data_r_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
`ifdef AD1868_DESER_STATS_EN
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (fall.latch) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (rise.clk) begin
               sh_l_d = {sh_l_q[WIDTH-2:0], lvl.data_l};
               sh_r_d = {sh_r_q[WIDTH-2:0], lvl.data_r};
               if (cnt_q != BIT_CNT_MAX) begin
                  cnt_d = BIT_CNT_W'(cnt_q + 1'b1);
               end
            end
            if (fall.latch) begin
               if (cnt_d >= WORD_BITS) begin
                  data_l_d = sh_l_d;
                  data_r_d = sh_r_d;
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
               end else begin
`ifdef AD1868_DESER_STATS_EN
                  locked_d = 1'b0;
                  if (err_q != '1) begin
                     err_d = ERR_CNT_W'(err_q + 1'b1);
                  end
`endif
               end
               cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_data_l = data_l_q;
   assign bus.o_data_r = data_r_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_locked = locked_q;
`ifdef AD1868_DESER_STATS_EN
   assign bus.o_err_cnt = err_q;
`else
   assign bus.o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ad1868_deserializer.sv
// Directed bench for ad1868_deserializer with a frame-level expected-output model.
// Honors AD1868_DESER_STATS_EN the same way as the RTL.
module tb_ad1868_deserializer;

   localparam int unsigned W   = 16;
   localparam int          LAT = 4;

   typedef struct {
      int           cyc;
      bit           v;
      logic [W-1:0] l;
      logic [W-1:0] r;
      bit           lk;
      logic [7:0]   err;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_valid = 0;
   int   last_valid_cyc = -1;
   bit   chk_en = 1'b0;

   ad1868_deserializer_if #(.WIDTH(W)) bus ();

   ad1868_deserializer #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .i_mclk (clk),
      .i_rst  (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level model: future state computed at stimulus time, applied at its due cycle
   ev_t          evq[$];
   bit           bq_l[$];
   bit           bq_r[$];
   bit           armed = 1'b0;
   logic [W-1:0] mf_l = '0, mf_r = '0;
   bit           mf_lk = 1'b0;
   logic [7:0]   mf_err = '0;
   logic [W-1:0] m_l = '0, m_r = '0;
   bit           m_lk = 1'b0;
   logic [7:0]   m_err = '0;

   task automatic push_ev(input int c, input bit v);
      ev_t e;
      e.cyc = c; e.v = v; e.l = mf_l; e.r = mf_r; e.lk = mf_lk; e.err = mf_err;
      evq.push_back(e);
   endtask

   task automatic model_latch(input int c);
      bit v;
      v = 1'b0;
      if (!armed) begin
         armed = 1'b1;
      end else if (bq_l.size() >= int'(W)) begin
         for (int i = 0; i < int'(W); i++) begin
            mf_l[i] = bq_l[bq_l.size()-1-i];
            mf_r[i] = bq_r[bq_r.size()-1-i];
         end
         mf_lk = 1'b1;
         v = 1'b1;
      end else begin
`ifdef AD1868_DESER_STATS_EN
         mf_lk = 1'b0;
         if (mf_err != 8'd255) mf_err = mf_err + 8'd1;
`endif
      end
      bq_l.delete();
      bq_r.delete();
      push_ev(c + LAT, v);
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         ev_t e;
         bit  exp_v;
         exp_v = 1'b0;
         while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            e = evq.pop_front();
            m_l = e.l; m_r = e.r; m_lk = e.lk; m_err = e.err;
            exp_v = e.v;
         end
         checks++;
         if (bus.o_valid !== exp_v || bus.o_data_l !== m_l || bus.o_data_r !== m_r ||
             bus.o_locked !== m_lk || bus.o_err_cnt !== m_err) begin
            errors++;
            $display("FAIL cycle_cmp @%0d: got v=%b l=%h r=%h lk=%b err=%0d, expected v=%b l=%h r=%h lk=%b err=%0d",
                     cyc, bus.o_valid, bus.o_data_l, bus.o_data_r, bus.o_locked, bus.o_err_cnt,
                     exp_v, m_l, m_r, m_lk, m_err);
         end
         if (bus.o_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit: 8 mclk low with data set, then 8 mclk high; optional coincident latch fall
   task automatic send_bit(input bit bl, input bit br, input bit with_latch, output int lc);
      lc = -1;
      @(negedge clk);
      bus.i_ad_clk = 1'b0; bus.i_ad_data_l = bl; bus.i_ad_data_r = br;
      if (with_latch) bus.i_ad_latch = 1'b1;
      idle(8);
      bus.i_ad_clk = 1'b1;
      bq_l.push_back(bl);
      bq_r.push_back(br);
      if (with_latch) begin
         bus.i_ad_latch = 1'b0;
         lc = cyc;
         model_latch(cyc);
      end
      idle(7);
   endtask

   task automatic latch_pulse(output int lc);
      @(negedge clk);
      bus.i_ad_clk = 1'b0; bus.i_ad_latch = 1'b1;
      idle(6);
      bus.i_ad_latch = 1'b0;
      lc = cyc;
      model_latch(cyc);
      idle(6);
   endtask

   task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n,
                        input bit coinc, output int lc);
      int t;
      lc = -1;
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(l[i], r[i], coinc && (i == 0), t);
         if (t >= 0) lc = t;
      end
      if (coinc) begin
         @(negedge clk);
         bus.i_ad_clk = 1'b0;
         idle(8);
      end else begin
         latch_pulse(lc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_ad_clk = 1'b0; bus.i_ad_latch = 1'b0;
      armed = 1'b0;
      bq_l.delete(); bq_r.delete();
      mf_l = '0; mf_r = '0; mf_lk = 1'b0; mf_err = '0;
      push_ev(cyc + 1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle(4);
   endtask

   initial begin
      int lc;
      int nv0;
      bus.i_ad_clk = 1'b0; bus.i_ad_data_l = 1'b0; bus.i_ad_data_r = 1'b0; bus.i_ad_latch = 1'b0;
      rst = 1'b1;
      idle(4);
      rst = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_data_l", bus.o_data_l, 0);
      chk("rst_data_r", bus.o_data_r, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_locked", bus.o_locked, 0);
      chk("rst_err", bus.o_err_cnt, 0);

      // Arm, then first full word
      latch_pulse(lc);
      idle(4);
      chk("arm_no_valid", n_valid, 0);
      nv0 = n_valid;
      frame(32'h8001, 32'h7FFE, 16, 1'b0, lc);
      idle(4);
      chk("t1_data_l", bus.o_data_l, 16'h8001);
      chk("t1_data_r", bus.o_data_r, 16'h7FFE);
      chk("t1_locked", bus.o_locked, 1);
      chk("t1_valid_count", n_valid - nv0, 1);
      chk("t1_latency", last_valid_cyc - lc, 4);

      // 18-bit word keeps the last 16 bits
      frame(32'h31234, 32'h2ABCD, 18, 1'b0, lc);
      idle(4);
      chk("t2_data_l", bus.o_data_l, 16'h1234);
      chk("t2_data_r", bus.o_data_r, 16'hABCD);
      chk("t2_err", bus.o_err_cnt, 0);

      // Short word: dropped
      nv0 = n_valid;
      frame(32'hABC, 32'h123, 12, 1'b0, lc);
      idle(4);
      chk("t3_no_valid", n_valid - nv0, 0);
      chk("t3_hold_l", bus.o_data_l, 16'h1234);
      chk("t3_hold_r", bus.o_data_r, 16'hABCD);
`ifdef AD1868_DESER_STATS_EN
      chk("t3_err", bus.o_err_cnt, 1);
      chk("t3_locked", bus.o_locked, 0);
`else
      chk("t3_locked", bus.o_locked, 1);
`endif

      // Latch fall coincident with the final bit's clock rise
      frame(32'hCAF1, 32'h0F0F, 16, 1'b1, lc);
      idle(4);
      chk("t4_data_l", bus.o_data_l, 16'hCAF1);
      chk("t4_data_r", bus.o_data_r, 16'h0F0F);
      chk("t4_locked", bus.o_locked, 1);
      chk("t4_latency", last_valid_cyc - lc, 4);

      // Reset mid-word, then arming frame, then a real frame
      for (int i = 15; i >= 7; i--) begin
         int t;
         send_bit(1'b1, 1'b0, 1'b0, t);
      end
      do_reset();
      chk("t5_rst_l", bus.o_data_l, 0);
      chk("t5_rst_r", bus.o_data_r, 0);
      chk("t5_rst_locked", bus.o_locked, 0);
      nv0 = n_valid;
      frame(32'h1111, 32'h2222, 16, 1'b0, lc);
      idle(4);
      chk("t5_arm_no_valid", n_valid - nv0, 0);
      chk("t5_arm_locked", bus.o_locked, 0);
      frame(32'h5A5A, 32'hA5A5, 16, 1'b0, lc);
      idle(4);
      chk("t5_data_l", bus.o_data_l, 16'h5A5A);
      chk("t5_data_r", bus.o_data_r, 16'hA5A5);
      chk("t5_locked", bus.o_locked, 1);

      // Many empty frames: error counter saturation
      nv0 = n_valid;
      repeat (300) latch_pulse(lc);
      idle(6);
      chk("t6_no_valid", n_valid - nv0, 0);
      chk("t6_hold_l", bus.o_data_l, 16'h5A5A);
`ifdef AD1868_DESER_STATS_EN
      chk("t6_err_sat", bus.o_err_cnt, 255);
      chk("t6_locked", bus.o_locked, 0);
`else
      chk("t6_err", bus.o_err_cnt, 0);
      chk("t6_locked", bus.o_locked, 1);
`endif

      idle(10);
      chk("events_drained", evq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
